// File: rtl/xbus_hub.sv
// Shared XBus segment for MC9999 x-ports: round-robin writer arbitration,
// broadcast or round-robin single-reader delivery, and a game-time stall flag.
module xbus_hub #(
  parameter int N_PORTS        = 4,
  parameter int WIDTH          = 11,
  parameter int BROADCAST      = 1,
  parameter int DEADLOCK_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       posedge_big_clk,
  input  logic [N_PORTS*WIDTH-1:0]   x_in,
  input  logic [N_PORTS-1:0]         x_write_in,
  input  logic [N_PORTS-1:0]         x_read_in,
  output logic [N_PORTS*WIDTH-1:0]   x_out,
  output logic [N_PORTS-1:0]         x_write_out,
  output logic [N_PORTS-1:0]         x_read_out,
  output logic                       deadlock
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(DEADLOCK_TICKS + 1);

  typedef enum logic [1:0] {IDLE, XFER, COOL} state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       dl_q, dl_d;
  logic [N_PORTS*WIDTH-1:0]   xout_q, xout_d;
  logic [N_PORTS-1:0]         wout_q, wout_d;
  logic [N_PORTS-1:0]         rout_q, rout_d;

  logic [N_PORTS-1:0]         wr_set, rd_set;
  logic [PW-1:0]              g_idx, t_idx;
  logic signed [WIDTH-1:0]    wdata;

  // First set bit of req at or above ptr, wrapping; rotation avoids a variable bit index.
  function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [PW-1:0]      ptr);
    logic [2*N_PORTS-1:0] dbl;
    logic [PW-1:0]        pick;
    logic                 found;
    int                   s;
    dbl   = {req, req} >> ptr;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        s     = int'(ptr) + i;
        if (s >= N_PORTS) s = s - N_PORTS;
        pick  = PW'(s);
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
    return (idx == PW'(N_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [N_PORTS-1:0] onehot(input logic [PW-1:0] idx);
    return N_PORTS'(1) << idx;
  endfunction

  always_comb begin
    wr_set = x_write_in;
    rd_set = x_read_in & ~x_write_in;
    g_idx  = rr_pick(wr_set, wptr_q);
    t_idx  = rr_pick(rd_set, rptr_q);
    wdata  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (g_idx == PW'(i)) wdata = x_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    xout_d  = '0;
    wout_d  = '0;
    rout_d  = '0;
    case (state_q)
      IDLE: begin
        if (|wr_set && |rd_set) begin
          // Output flops are loaded here so the pulses appear exactly in XFER.
          state_d = XFER;
          xout_d  = {N_PORTS{wdata}};
          wout_d  = (BROADCAST != 0) ? rd_set : onehot(t_idx);
          rout_d  = onehot(g_idx);
          wptr_d  = ptr_next(g_idx);
          if (BROADCAST == 0) rptr_d = ptr_next(t_idx);
          cnt_d   = '0;
          dl_d    = 1'b0;
        end else if (!(|wr_set) && !(|rd_set)) begin
          cnt_d = '0;
        end else if (posedge_big_clk && cnt_q != CW'(DEADLOCK_TICKS)) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(DEADLOCK_TICKS)) dl_d = 1'b1;
        end
      end
      XFER:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dl_q    <= 1'b0;
      xout_q  <= '0;
      wout_q  <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      xout_q  <= xout_d;
      wout_q  <= wout_d;
      rout_q  <= rout_d;
    end
  end

  assign x_out       = xout_q;
  assign x_write_out = wout_q;
  assign x_read_out  = rout_q;
  assign deadlock    = dl_q;

endmodule

// File: tb/tb_xbus_hub.sv
// Directed bench for xbus_hub: a broadcast and a single-reader instance share stimulus.
module tb_xbus_hub;

  localparam int N = 4;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic           big;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   wr, rd;

  logic [N*W-1:0] xout_b, xout_s;
  logic [N-1:0]   wout_b, wout_s, rout_b, rout_s;
  logic           dl_b, dl_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbus_hub #(.N_PORTS(N), .WIDTH(W), .BROADCAST(1), .DEADLOCK_TICKS(4)) dut_b (
    .clk(clk), .reset(reset), .posedge_big_clk(big), .x_in(x_in),
    .x_write_in(wr), .x_read_in(rd), .x_out(xout_b),
    .x_write_out(wout_b), .x_read_out(rout_b), .deadlock(dl_b));

  xbus_hub #(.N_PORTS(N), .WIDTH(W), .BROADCAST(0), .DEADLOCK_TICKS(4)) dut_s (
    .clk(clk), .reset(reset), .posedge_big_clk(big), .x_in(x_in),
    .x_write_in(wr), .x_read_in(rd), .x_out(xout_s),
    .x_write_out(wout_s), .x_read_out(rout_s), .deadlock(dl_s));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input logic signed [W-1:0] d0, input logic signed [W-1:0] d1,
                                        input logic signed [W-1:0] d2, input logic signed [W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [N*W-1:0] rep(input logic signed [W-1:0] d);
    return {N{d}};
  endfunction

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = '0; big = 1'b0; x_in = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_wout_b"}, 64'(wout_b), 64'd0);
    chk({nm, "_rout_b"}, 64'(rout_b), 64'd0);
    chk({nm, "_xout_b"}, 64'(xout_b), 64'd0);
    chk({nm, "_wout_s"}, 64'(wout_s), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]          wr;
    logic [N-1:0]          rd;
    logic [N*W-1:0]        xin;
    logic [N-1:0]          rout;
    logic [N-1:0]          wout_b;
    logic [N-1:0]          wout_s;
    logic signed [W-1:0]   data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [N-1:0] exp_s [3];
    int ev, last;

    tbl[0] = '{4'b0001, 4'b0100, pk(11'sd123, 11'sd0, 11'sd0, 11'sd0),   4'b0001, 4'b0100, 4'b0100, 11'sd123};
    tbl[1] = '{4'b0010, 4'b1101, pk(11'sd0, -11'sd999, 11'sd0, 11'sd0),  4'b0010, 4'b1101, 4'b1000, -11'sd999};
    tbl[2] = '{4'b0100, 4'b0101, pk(11'sd0, 11'sd0, 11'sd42, 11'sd0),    4'b0100, 4'b0001, 4'b0001, 11'sd42};
    tbl[3] = '{4'b1001, 4'b0010, pk(11'sd5, 11'sd0, 11'sd0, 11'sd7),     4'b1000, 4'b0010, 4'b0010, 11'sd7};
    tbl[4] = '{4'b1001, 4'b0010, pk(11'sd5, 11'sd0, 11'sd0, 11'sd7),     4'b0001, 4'b0010, 4'b0010, 11'sd5};
    tbl[5] = '{4'b0110, 4'b1001, pk(11'sd0, 11'h400, 11'sd1023, 11'sd0), 4'b0010, 4'b1001, 4'b1000, 11'h400};
    tbl[6] = '{4'b0110, 4'b1001, pk(11'sd0, 11'h400, 11'sd1023, 11'sd0), 4'b0100, 4'b1001, 4'b0001, 11'sd1023};

    do_reset();
    chk_quiet("reset");
    chk("reset_dl", 64'(dl_b), 64'd0);

    // Table: each vector is one full IDLE -> XFER -> COOL -> IDLE round.
    for (int i = 0; i < 7; i++) begin
      x_in = tbl[i].xin; wr = tbl[i].wr; rd = tbl[i].rd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_rout_b", i), 64'(rout_b), 64'(tbl[i].rout));
      chk($sformatf("v%0d_rout_s", i), 64'(rout_s), 64'(tbl[i].rout));
      chk($sformatf("v%0d_wout_b", i), 64'(wout_b), 64'(tbl[i].wout_b));
      chk($sformatf("v%0d_wout_s", i), 64'(wout_s), 64'(tbl[i].wout_s));
      chk($sformatf("v%0d_xout_b", i), 64'(xout_b), 64'(rep(tbl[i].data)));
      chk($sformatf("v%0d_dl", i), 64'(dl_b), 64'd0);
      wr = '0; rd = '0;
      @(posedge clk); #1;
      chk_quiet($sformatf("v%0d_cool", i));
      @(posedge clk); #1;
    end

    // Single-reader round-robin from a fresh reset
    do_reset();
    exp_s[0] = 4'b0001; exp_s[1] = 4'b0100; exp_s[2] = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      x_in = pk(11'sd0, -11'sd999, 11'sd0, 11'sd0); wr = 4'b0010; rd = 4'b1101;
      @(posedge clk); #1;
      chk($sformatf("single%0d_wout_s", k), 64'(wout_s), 64'(exp_s[k]));
      chk($sformatf("single%0d_wout_b", k), 64'(wout_b), 64'b1101);
      chk($sformatf("single%0d_xout_s", k), 64'(xout_s), 64'(rep(-11'sd999)));
      wr = '0; rd = '0;
      @(posedge clk); @(posedge clk); #1;
    end

    // Held writers 0 and 3 with a continuous reader on port 1
    do_reset();
    x_in = pk(11'sd5, 11'sd0, 11'sd0, 11'sd7); wr = 4'b1001; rd = 4'b0010;
    ev = 0; last = -1;
    for (int c = 0; c < 20 && ev < 4; c++) begin
      @(posedge clk); #1;
      if (rout_b != '0) begin
        chk($sformatf("rr%0d_grant", ev), 64'(rout_b), (ev % 2 == 0) ? 64'b0001 : 64'b1000);
        chk($sformatf("rr%0d_data", ev), 64'(xout_b),
            (ev % 2 == 0) ? 64'(rep(11'sd5)) : 64'(rep(11'sd7)));
        if (ev > 0) chk($sformatf("rr%0d_gap", ev), 64'(c - last), 64'd3);
        last = c;
        ev++;
      end
    end
    chk("rr_events", 64'(ev), 64'd4);
    wr = '0; rd = '0;

    // Deadlock: writer on port 1, no reader, then a late reader
    do_reset();
    x_in = pk(11'sd0, 11'sd17, 11'sd0, 11'sd0); wr = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      big = 1'b1;
      @(posedge clk); #1;
      big = 1'b0;
      if (k == 3) chk("dl_after3", 64'(dl_b), 64'd0);
      if (k == 4) chk("dl_after4", 64'(dl_b), 64'd1);
      if (k == 5) chk("dl_sat", 64'(dl_s), 64'd1);
      chk($sformatf("dl_nopulse%0d", k), 64'(rout_b), 64'd0);
      @(posedge clk); @(posedge clk); #1;
    end
    rd = 4'b1000;
    @(posedge clk); #1;
    chk("dl_clear", 64'(dl_b), 64'd0);
    chk("dl_wout", 64'(wout_b), 64'b1000);
    chk("dl_rout", 64'(rout_b), 64'b0010);
    chk("dl_xout", 64'(xout_b), 64'(rep(11'sd17)));
    wr = '0; rd = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset during XFER: pointer returns to 0, held request re-granted
    do_reset();
    x_in = pk(11'sd0, 11'sd0, 11'sd300, 11'sd0); wr = 4'b0100; rd = 4'b0001;
    @(posedge clk); #1;
    chk("rst_pre_rout", 64'(rout_b), 64'b0100);
    wr = '0; rd = '0;
    @(posedge clk); @(posedge clk); #1;
    x_in = pk(11'sd11, 11'sd22, 11'sd0, 11'sd0); wr = 4'b0011; rd = 4'b1000;
    @(posedge clk); #1;
    chk("rst_wrap_rout", 64'(rout_b), 64'b0001);
    chk("rst_wrap_xout", 64'(xout_b), 64'(rep(11'sd11)));
    reset = 1'b1;
    @(posedge clk); #1;
    chk_quiet("rst_mid");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_regrant_rout", 64'(rout_b), 64'b0001);
    chk("rst_regrant_wout", 64'(wout_b), 64'b1000);
    chk("rst_regrant_xout", 64'(xout_b), 64'(rep(11'sd11)));
    wr = '0; rd = '0;
    @(posedge clk); #1;
    chk_quiet("rst_cool");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
